tx_fifo_ctrl: RTL and testbench

Transmit-side buffer and launcher for the UART. Accepts bytes from the host side in the system clock domain, stores them in a DEPTH-entry FIFO, and feeds them one at a time to the downstream transmitter through its `txff_ena`/`data_in` inputs. It pops the next entry only after the transmitter has returned `tx_done`, so back-to-back frames go out without host involvement.

---
 rtl/uart_pkg.sv | 14 +
 rtl/tx_fifo_mem.sv | 28 ++
 rtl/tx_fifo_ctrl.sv | 138 +++++++++++++
 tb/tb_tx_fifo_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: launcher FSM states and default widths,
// common to tx_fifo_ctrl and the transmitter.
package uart_pkg;

   localparam int UART_NBITS = 8;
   localparam int UART_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      BUSY = 2'd2
   } tx_state_t;

endpackage

// File: rtl/tx_fifo_mem.sv
// Transmit FIFO storage: DEPTH x NBITS register array, synchronous write,
// asynchronous read. No reset; validity is tracked by the controller.
module tx_fifo_mem
   import uart_pkg::*;
#(
   parameter  int NBITS = UART_NBITS,
   parameter  int DEPTH = UART_DEPTH,
   localparam int AW    = $clog2(DEPTH)
)
(
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_ptr,
   input  logic [NBITS-1:0] wr_data,
   input  logic [AW-1:0]    rd_ptr,
   output logic [NBITS-1:0] rd_data
);

   logic [NBITS-1:0] mem [DEPTH];

   // Store the host word at the write pointer.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/tx_fifo_ctrl.sv
// Transmit FIFO controller and frame launcher for the UART transmitter.
// Optional feature macro: TX_FIFO_OVF_EN adds the sticky ovf flag and its
// ovf_clr input; without it, writes while full are dropped silently.
module tx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter  int NBITS = UART_NBITS,
   parameter  int DEPTH = UART_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
)
(
   input  logic             clk,
   input  logic             tx_rst,
   input  logic             bdtick,
   input  logic             wr_en,
   input  logic [NBITS-1:0] wr_data,
   input  logic             tx_done,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic             txff_ena,
   output logic [NBITS-1:0] data_out
`ifdef TX_FIFO_OVF_EN
   ,
   output logic             ovf,
   input  logic             ovf_clr
`endif
);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [NBITS-1:0] rd_data;
   logic [CW-1:0]    count_nxt;
   logic             wr_acc;
   logic             pop;
   logic             tx_done_q;

   tx_state_t        state;
   tx_state_t        state_nxt;
   logic             txff_ena_nxt;
   logic [NBITS-1:0] data_out_nxt;

   assign wr_acc = wr_en && !full;

   tx_fifo_mem #(
      .NBITS (NBITS),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_ptr  (wr_ptr),
      .wr_data (wr_data),
      .rd_ptr  (rd_ptr),
      .rd_data (rd_data)
   );

   // Launcher next state: pop into data_out, hold for a tick, wait for tx_done edge.
   always_comb begin
      state_nxt    = state;
      txff_ena_nxt = txff_ena;
      data_out_nxt = data_out;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop          = 1'b1;
               data_out_nxt = rd_data;
               txff_ena_nxt = 1'b1;
               state_nxt    = LOAD;
            end
         end
         LOAD: begin
            // A tick on the entry edge was sampled in IDLE, so it never counts here.
            if (bdtick) begin
               txff_ena_nxt = 1'b0;
               state_nxt    = BUSY;
            end
         end
         BUSY: begin
            if (tx_done && !tx_done_q) state_nxt = IDLE;
         end
         default: begin
            txff_ena_nxt = 1'b0;
            state_nxt    = IDLE;
         end
      endcase
   end

   // Occupancy after this edge's accepted write and/or pop.
   always_comb begin
      count_nxt = count;
      if (wr_acc && !pop)      count_nxt = count + CW'(1);
      else if (!wr_acc && pop) count_nxt = count - CW'(1);
   end

   // Launcher state, outputs and tx_done history.
   always_ff @(posedge clk or negedge tx_rst) begin
      if (!tx_rst) begin
         state     <= IDLE;
         txff_ena  <= 1'b0;
         data_out  <= '0;
         tx_done_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         txff_ena  <= txff_ena_nxt;
         data_out  <= data_out_nxt;
         tx_done_q <= tx_done;
      end
   end

   // FIFO pointers and registered occupancy flags.
   always_ff @(posedge clk or negedge tx_rst) begin
      if (!tx_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == CW'(DEPTH));
      end
   end

`ifdef TX_FIFO_OVF_EN
   // Sticky overflow on any write attempt while full; set beats clear.
   always_ff @(posedge clk or negedge tx_rst) begin
      if (!tx_rst)             ovf <= 1'b0;
      else if (wr_en && full)  ovf <= 1'b1;
      else if (ovf_clr)        ovf <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Bench for tx_fifo_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based transmitter model.
module tb_tx_fifo_ctrl;
   import uart_pkg::*;

   localparam int NBITS = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int NRAND = 60;

   logic             clk = 1'b0;
   logic             tx_rst;
   logic             bdtick;
   logic             wr_en;
   logic [NBITS-1:0] wr_data;
   logic             tx_done;
   logic             full;
   logic             empty;
   logic [CW-1:0]    count;
   logic             txff_ena;
   logic [NBITS-1:0] data_out;
`ifdef TX_FIFO_OVF_EN
   logic             ovf;
   logic             ovf_clr;
`endif

   // bdtick/tx_done come from either the manual drivers or the transmitter model.
   logic model_on;
   logic man_bd, man_td;
   logic m_bd, m_td;
   assign bdtick  = model_on ? m_bd : man_bd;
   assign tx_done = model_on ? m_td : man_td;

   int total = 0;
   int bad   = 0;

   // Randomized-run bookkeeping.
   logic [NBITS-1:0] exp_q [$];
   int pushed   = 0;
   int done_cnt = 0;
   int captured = 0;

   tx_fifo_ctrl #(
      .NBITS (NBITS),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .tx_rst   (tx_rst),
      .bdtick   (bdtick),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .tx_done  (tx_done),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .txff_ena (txff_ena),
      .data_out (data_out)
`ifdef TX_FIFO_OVF_EN
      ,
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] obs();
      return {txff_ena, data_out, count, empty, full};
   endfunction

   function automatic logic [15:0] pk(input logic ena, input logic [7:0] d,
                                      input logic [4:0] c, input logic e, input logic f);
      return {ena, d, c, e, f};
   endfunction

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       bd;
      logic       td;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic bd,
                               input logic td, input logic [15:0] exp);
      vec_t v;
      v.wr = wr; v.d = d; v.bd = bd; v.td = td; v.exp = exp;
      return v;
   endfunction

   // Manually serve one frame: wait for launch, check word, tick, complete.
   task automatic serve(input logic [7:0] exp, input int idx);
      int n = 0;
      while (!txff_ena && n < 50) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("frame%0d launch", idx), {31'd0, txff_ena}, 32'd1);
      check($sformatf("frame%0d data", idx), {24'd0, data_out}, {24'd0, exp});
      man_bd = 1'b1;
      man_td = 1'b0;
      @(negedge clk);
      man_bd = 1'b0;
      check($sformatf("frame%0d drop", idx), {31'd0, txff_ena}, 32'd0);
      repeat (3) @(negedge clk);
      man_td = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      bit seen_ena;

      model_on = 1'b0;
      man_bd = 1'b0; man_td = 1'b0; m_bd = 1'b0; m_td = 1'b0;
      wr_en = 1'b0; wr_data = '0;
`ifdef TX_FIFO_OVF_EN
      ovf_clr = 1'b0;
`endif
      tx_rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset state", {16'd0, obs()}, {16'd0, pk(0, 8'h00, 5'd0, 1, 0)});
`ifdef TX_FIFO_OVF_EN
      check("reset ovf", {31'd0, ovf}, 32'd0);
`endif
      tx_rst = 1'b1;
      for (int i = 0; i < 100; i++) begin
         man_bd = ($urandom_range(0, 3) == 0);
         @(negedge clk);
      end
      man_bd = 1'b0;
      check("idle 100", {16'd0, obs()}, {16'd0, pk(0, 8'h00, 5'd0, 1, 0)});

      // Directed single frame then three back-to-back frames.
      //               wr  data   bd td   ena dout   cnt emp ful
      tbl[0]  = mk(1, 8'hA5, 0, 0, pk(0, 8'h00, 5'd1, 0, 0));
      tbl[1]  = mk(0, 8'h00, 1, 0, pk(1, 8'hA5, 5'd0, 1, 0));
      tbl[2]  = mk(0, 8'h00, 0, 0, pk(1, 8'hA5, 5'd0, 1, 0));
      tbl[3]  = mk(0, 8'h00, 1, 0, pk(0, 8'hA5, 5'd0, 1, 0));
      tbl[4]  = mk(1, 8'h01, 0, 0, pk(0, 8'hA5, 5'd1, 0, 0));
      tbl[5]  = mk(1, 8'h02, 0, 0, pk(0, 8'hA5, 5'd2, 0, 0));
      tbl[6]  = mk(1, 8'h03, 0, 1, pk(0, 8'hA5, 5'd3, 0, 0));
      tbl[7]  = mk(0, 8'h00, 0, 1, pk(1, 8'h01, 5'd2, 0, 0));
      tbl[8]  = mk(0, 8'h00, 1, 1, pk(0, 8'h01, 5'd2, 0, 0));
      tbl[9]  = mk(0, 8'h00, 0, 0, pk(0, 8'h01, 5'd2, 0, 0));
      tbl[10] = mk(0, 8'h00, 0, 1, pk(0, 8'h01, 5'd2, 0, 0));
      tbl[11] = mk(0, 8'h00, 0, 1, pk(1, 8'h02, 5'd1, 0, 0));
      tbl[12] = mk(0, 8'h00, 1, 1, pk(0, 8'h02, 5'd1, 0, 0));
      tbl[13] = mk(0, 8'h00, 0, 0, pk(0, 8'h02, 5'd1, 0, 0));
      tbl[14] = mk(0, 8'h00, 0, 1, pk(0, 8'h02, 5'd1, 0, 0));
      tbl[15] = mk(0, 8'h00, 0, 1, pk(1, 8'h03, 5'd0, 1, 0));
      tbl[16] = mk(0, 8'h00, 1, 1, pk(0, 8'h03, 5'd0, 1, 0));
      for (int i = 0; i < 17; i++) begin
         wr_en = tbl[i].wr; wr_data = tbl[i].d;
         man_bd = tbl[i].bd; man_td = tbl[i].td;
         @(negedge clk);
         check($sformatf("vec%0d", i), {16'd0, obs()}, {16'd0, tbl[i].exp});
      end
      wr_en = 1'b0; man_bd = 1'b0; man_td = 1'b0;

      // Fill while the transmitter is busy, then overflow.
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h10 + i);
         @(negedge clk);
      end
      check("fill count", {27'd0, count}, 32'd16);
      check("fill full", {30'd0, full, empty}, 32'd2);
      wr_data = 8'hFF;
      @(negedge clk);
      wr_en = 1'b0;
      check("ovf drop count", {27'd0, count}, 32'd16);
`ifdef TX_FIFO_OVF_EN
      check("ovf set", {31'd0, ovf}, 32'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      check("ovf cleared", {31'd0, ovf}, 32'd0);
      wr_en = 1'b1; wr_data = 8'hFF;
      @(negedge clk);
      wr_en = 1'b0; ovf_clr = 1'b0;
      check("ovf set wins", {31'd0, ovf}, 32'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("ovf cleared again", {31'd0, ovf}, 32'd0);
`endif

      // Write while full in the same cycle as a pop.
      man_td = 1'b1;
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'hEE;
      @(negedge clk);
      wr_en = 1'b0;
      check("full+pop", {16'd0, obs()}, {16'd0, pk(1, 8'h10, 5'd15, 0, 0)});

      for (int i = 0; i < DEPTH; i++) serve(8'(8'h10 + i), i);
      repeat (5) @(negedge clk);
      check("drained", {16'd0, obs()}, {16'd0, pk(0, 8'h1F, 5'd0, 1, 0)});

      // Reset in LOAD with five entries queued.
      man_td = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h31 + i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      check("pre-reset", {16'd0, obs()}, {16'd0, pk(1, 8'h31, 5'd5, 0, 0)});
      #2 tx_rst = 1'b0;
      #1 check("async reset", {16'd0, obs()}, {16'd0, pk(0, 8'h00, 5'd0, 1, 0)});
      @(negedge clk);
      tx_rst = 1'b1;
      seen_ena = 1'b0;
      for (int i = 0; i < 40; i++) begin
         man_bd = ($urandom_range(0, 3) == 0);
         man_td = (i > 20);
         @(negedge clk);
         if (txff_ena) seen_ena = 1'b1;
      end
      man_bd = 1'b0; man_td = 1'b0;
      check("no frame after reset", {31'd0, seen_ena}, 32'd0);
      check("post-reset empty", {27'd0, count}, 32'd0);

      // Randomized traffic against a queue-based transmitter model.
      tx_rst = 1'b0;
      @(negedge clk);
      tx_rst = 1'b1;
      model_on = 1'b1;
      fork
         begin
            for (int i = 0; i < NRAND; i++) begin
               int guard = 0;
               repeat ($urandom_range(0, 6)) @(negedge clk);
               while ((pushed - done_cnt) >= DEPTH && guard < 5000) begin
                  @(negedge clk);
                  guard++;
               end
               wr_en = 1'b1;
               wr_data = 8'($urandom);
               exp_q.push_back(wr_data);
               pushed++;
               @(negedge clk);
               wr_en = 1'b0;
            end
         end
         begin
            int guard = 0;
            bit busy = 1'b0;
            bit chk_drop = 1'b0;
            bit proto_err = 1'b0;
            int left = 0;
            logic [7:0] want;
            while (captured < NRAND && guard < 20000) begin
               @(negedge clk);
               guard++;
               if (chk_drop && txff_ena) proto_err = 1'b1;
               chk_drop = 1'b0;
               if (busy && txff_ena) proto_err = 1'b1;
               m_bd = ($urandom_range(0, 3) == 0);
               if (m_bd) begin
                  if (busy) begin
                     left--;
                     if (left == 0) begin
                        busy = 1'b0;
                        m_td = 1'b1;
                        done_cnt++;
                     end
                  end else if (txff_ena) begin
                     want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                     check($sformatf("rand frame%0d", captured), {24'd0, data_out}, {24'd0, want});
                     captured++;
                     busy = 1'b1;
                     left = 10;
                     m_td = 1'b0;
                     chk_drop = 1'b1;
                  end
               end
            end
            @(negedge clk);
            m_bd = 1'b0;
            check("rand protocol", {31'd0, proto_err}, 32'd0);
         end
      join
      check("rand frames", captured, NRAND);
      check("rand queue left", exp_q.size(), 0);
      repeat (5) @(negedge clk);
      check("rand end state", {29'd0, txff_ena, empty, full}, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
